// File: rtl/branch_predictor.sv
// branch_predictor: BHT of 2-bit saturating counters indexed by pc[IDX_W+1:2].
// An INIT sweep loads every counter with weak-not-taken (01) after reset. The
// predictor then serves one lookup and one resolution per cycle, raising a
// redirect pulse on a mispredict and counting mispredicts with saturation.
// Optional macro BP_BYPASS_EN: a lookup that hits the entry being updated in
// the same cycle returns the post-update counter instead of the stored one.
module branch_predictor #(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned DATA_SIZE   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_ready,
    input  logic                 i_pred_valid,
    input  logic [DATA_SIZE-1:0] i_pred_pc,
    output logic                 o_pred_valid,
    output logic                 o_pred_taken,
    input  logic                 i_res_valid,
    input  logic [DATA_SIZE-1:0] i_res_pc,
    input  logic                 i_res_taken,
    input  logic                 i_res_pred_taken,
    input  logic [DATA_SIZE-1:0] i_res_target,
    output logic                 o_redirect,
    output logic [DATA_SIZE-1:0] o_redirect_pc,
    output logic [31:0]          o_mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned CNT_W = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   sweep_q;
    logic [IDX_W-1:0]   sweep_d;
    logic               sweep_last;

    logic [1:0]         bht [BHT_ENTRIES];
    logic [IDX_W-1:0]   pred_idx;
    logic [IDX_W-1:0]   res_idx;
    logic [1:0]         pred_cnt;
    logic [1:0]         res_cnt;
    logic [1:0]         res_cnt_upd;
    logic               bht_we;
    logic [IDX_W-1:0]   bht_waddr;
    logic [1:0]         bht_wdata;

    logic               ready_q;
    logic               ready_d;
    logic               pred_valid_q;
    logic               pred_valid_d;
    logic               pred_taken_q;
    logic               pred_taken_d;
    logic               redirect_q;
    logic               redirect_d;
    logic [DATA_SIZE-1:0] redirect_pc_q;
    logic [DATA_SIZE-1:0] redirect_pc_d;
    logic [CNT_W-1:0]   mcnt_q;
    logic [CNT_W-1:0]   mcnt_d;

    // PC bits above and below the index field do not affect the table
    logic               unused_pred_pc_bits;
    assign unused_pred_pc_bits = ^{i_pred_pc[DATA_SIZE-1:IDX_W+2], i_pred_pc[1:0]};

    assign pred_idx   = i_pred_pc[IDX_W+1:2];
    assign res_idx    = i_res_pc[IDX_W+1:2];
    assign sweep_last = (sweep_q == IDX_W'(BHT_ENTRIES - 1));

    // Table read ports and saturating counter update for the resolving branch
    always_comb begin
        pred_cnt    = bht[pred_idx];
        res_cnt     = bht[res_idx];
        res_cnt_upd = res_cnt;
        if (i_res_taken) begin
            if (res_cnt != 2'b11) res_cnt_upd = res_cnt + 2'b01;
        end else begin
            if (res_cnt != 2'b00) res_cnt_upd = res_cnt - 2'b01;
        end
    end

    // FSM state register and sweep index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // FSM next state: sweep every entry once, then stay in RUN until reset
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_last) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs: table write port and next values of the registered outputs
    always_comb begin
        ready_d       = (state_d == ST_RUN);
        pred_valid_d  = 1'b0;
        pred_taken_d  = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        mcnt_d        = mcnt_q;
        bht_we        = 1'b0;
        bht_waddr     = sweep_q;
        bht_wdata     = 2'b01;
        case (state_q)
            ST_INIT: begin
                bht_we    = 1'b1;
                bht_waddr = sweep_q;
                bht_wdata = 2'b01;
            end
            ST_RUN: begin
                if (i_pred_valid) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = pred_cnt[1];
`ifdef BP_BYPASS_EN
                    if (i_res_valid && (res_idx == pred_idx)) pred_taken_d = res_cnt_upd[1];
`endif
                end
                if (i_res_valid) begin
                    bht_we    = 1'b1;
                    bht_waddr = res_idx;
                    bht_wdata = res_cnt_upd;
                    if (i_res_taken != i_res_pred_taken) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = i_res_taken ? i_res_target
                                                    : DATA_SIZE'(i_res_pc + DATA_SIZE'(4));
                        if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset discards any pending redirect
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_q       <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            mcnt_q        <= '0;
        end else begin
            ready_q       <= ready_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            mcnt_q        <= mcnt_d;
        end
    end

    // Counter table: single write port shared by the init sweep and resolutions
    always_ff @(posedge i_clk) begin
        if (!i_rst && bht_we) bht[bht_waddr] <= bht_wdata;
    end

    assign o_ready          = ready_q;
    assign o_pred_valid     = pred_valid_q;
    assign o_pred_taken     = pred_taken_q;
    assign o_redirect       = redirect_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_mispredict_cnt = mcnt_q;

endmodule
